// File: rtl/rob_if.sv
// Issue, result-broadcast and commit signals between the pipeline and the reorder buffer.
// Global enable and flush travel with the bus so one bundle describes a whole cycle of activity.
interface rob_if;
    logic        rdy;
    logic        rob_flush;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_is_branch_or_store;
    logic        alloc_is_store;
    logic [31:0] alloc_value;
    logic [3:0]  alloc_tag;
    logic        rob_full;
    logic        simple_ins_commit;
    logic [3:0]  simple_ins_rename;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        register_update_flag;
    logic [4:0]  register_commit_dest;
    logic [31:0] register_commit_value;
    logic [3:0]  rename_of_commit_ins;
    logic        store_commit;
    logic [3:0]  store_commit_tag;

    modport master (
        output rdy, rob_flush, alloc_valid, alloc_rd, alloc_is_branch_or_store, alloc_is_store,
               alloc_value, simple_ins_commit, simple_ins_rename, cdb_valid, cdb_tag, cdb_value,
        input  alloc_tag, rob_full, register_update_flag, register_commit_dest,
               register_commit_value, rename_of_commit_ins, store_commit, store_commit_tag
    );

    modport slave (
        input  rdy, rob_flush, alloc_valid, alloc_rd, alloc_is_branch_or_store, alloc_is_store,
               alloc_value, simple_ins_commit, simple_ins_rename, cdb_valid, cdb_tag, cdb_value,
        output alloc_tag, rob_full, register_update_flag, register_commit_dest,
               register_commit_value, rename_of_commit_ins, store_commit, store_commit_tag
    );
endinterface

// File: rtl/reorder_buffer.sv
// 16-entry in-order-commit reorder buffer with one commit per cycle and flush.
// Optional feature: define ROB_COMMIT_COUNT_EN to add the commit_count output.
module reorder_buffer #(
    parameter int ROB_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef ROB_COMMIT_COUNT_EN
    output logic [31:0] commit_count,
`endif
    rob_if.slave        rob
);
    localparam logic [4:0] FULL = 5'(ROB_DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic        no_wb;
        logic        is_store;
        logic [31:0] value;
    } entry_t;

    logic [ROB_DEPTH-1:0] busy_q, busy_d, ready_q, ready_d;
    entry_t               data_q [ROB_DEPTH];
    entry_t               data_d [ROB_DEPTH];
    logic [3:0]           head_q, head_d, tail_q, tail_d;
    logic [4:0]           count_q, count_d;
    logic                 reg_update_q, reg_update_d, store_commit_q, store_commit_d;
    logic [4:0]           commit_dest_q, commit_dest_d;
    logic [31:0]          commit_value_q, commit_value_d;
    logic [3:0]           commit_tag_q, commit_tag_d, store_tag_q, store_tag_d;
    logic                 do_alloc, do_commit;
    entry_t               head_ent;
`ifdef ROB_COMMIT_COUNT_EN
    logic [31:0]          commit_count_q, commit_count_d;
`endif

    assign do_alloc  = rob.alloc_valid && (count_q < FULL);
    assign do_commit = busy_q[head_q] && ready_q[head_q];
    assign head_ent  = data_q[head_q];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        busy_d         = busy_q;
        ready_d        = ready_q;
        data_d         = data_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        reg_update_d   = reg_update_q;
        store_commit_d = store_commit_q;
        commit_dest_d  = commit_dest_q;
        commit_value_d = commit_value_q;
        commit_tag_d   = commit_tag_q;
        store_tag_d    = store_tag_q;
`ifdef ROB_COMMIT_COUNT_EN
        commit_count_d = commit_count_q;
`endif
        if (rob.rdy) begin
            reg_update_d   = 1'b0;
            store_commit_d = 1'b0;
            if (rob.rob_flush) begin
                busy_d  = '0;
                ready_d = '0;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (rob.simple_ins_commit)
                    ready_d[rob.simple_ins_rename] = 1'b1;
                if (rob.cdb_valid && busy_q[rob.cdb_tag]) begin
                    ready_d[rob.cdb_tag]      = 1'b1;
                    data_d[rob.cdb_tag].value = rob.cdb_value;
                end
                // Tail never equals a busy head while count<16, so alloc and commit touch different slots.
                if (do_alloc) begin
                    busy_d[tail_q]  = 1'b1;
                    ready_d[tail_q] = 1'b0;
                    data_d[tail_q]  = '{rd: rob.alloc_rd, no_wb: rob.alloc_is_branch_or_store,
                                        is_store: rob.alloc_is_store, value: rob.alloc_value};
                    tail_d          = tail_q + 4'd1;
                end
                if (do_commit) begin
                    busy_d[head_q]  = 1'b0;
                    ready_d[head_q] = 1'b0;
                    head_d          = head_q + 4'd1;
                    if (!head_ent.no_wb) begin
                        reg_update_d   = 1'b1;
                        commit_dest_d  = head_ent.rd;
                        commit_value_d = head_ent.value;
                        commit_tag_d   = head_q;
                    end else if (head_ent.is_store) begin
                        store_commit_d = 1'b1;
                        store_tag_d    = head_q;
                    end
`ifdef ROB_COMMIT_COUNT_EN
                    commit_count_d = commit_count_q + 32'd1;
`endif
                end
                count_d = count_q + {4'd0, do_alloc} - {4'd0, do_commit};
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q         <= '0;
            ready_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            reg_update_q   <= 1'b0;
            store_commit_q <= 1'b0;
            commit_dest_q  <= '0;
            commit_value_q <= '0;
            commit_tag_q   <= '0;
            store_tag_q    <= '0;
`ifdef ROB_COMMIT_COUNT_EN
            commit_count_q <= '0;
`endif
        end else begin
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            reg_update_q   <= reg_update_d;
            store_commit_q <= store_commit_d;
            commit_dest_q  <= commit_dest_d;
            commit_value_q <= commit_value_d;
            commit_tag_q   <= commit_tag_d;
            store_tag_q    <= store_tag_d;
`ifdef ROB_COMMIT_COUNT_EN
            commit_count_q <= commit_count_d;
`endif
        end
    end

    // NOTE: the payload array has no reset; a slot is only read after busy marks it written.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign rob.alloc_tag             = tail_q;
    assign rob.rob_full              = (count_q == FULL);
    assign rob.register_update_flag  = reg_update_q;
    assign rob.register_commit_dest  = commit_dest_q;
    assign rob.register_commit_value = commit_value_q;
    assign rob.rename_of_commit_ins  = commit_tag_q;
    assign rob.store_commit          = store_commit_q;
    assign rob.store_commit_tag      = store_tag_q;
`ifdef ROB_COMMIT_COUNT_EN
    assign commit_count              = commit_count_q;
`endif
endmodule
